// File: rtl/binary_counter_core.sv
// rtl/binary_counter_core.sv - up/down display counter stepped by a prescaled tick or a debounced button
module binary_counter_core #(
    parameter int WIDTH           = 6,
    parameter int CLK_HZ          = 50000000,
    parameter int TICK_HZ         = 1,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             manual_mode,
    input  logic             step_btn,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tick,
    output logic             wrap
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = $clog2(DIV);
    localparam int DW  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);
    localparam logic [DW-1:0] DEB_MAX = DW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE_LOW, WAIT_HIGH, HIGH, WAIT_LOW} deb_state_t;

    logic [PW-1:0] prescaler;
    logic          auto_active;
    logic          auto_en;
    logic          sync_meta;
    logic          sync_btn;
    deb_state_t    deb_state;
    deb_state_t    deb_state_next;
    logic [DW-1:0] deb_cnt;
    logic [DW-1:0] deb_cnt_next;
    logic          step_en;
    logic          count_en;

    // Leaving auto mode or dropping run restarts the tick period from zero.
    assign auto_active = run & ~manual_mode;
    assign auto_en     = auto_active && (prescaler == PRE_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescaler <= '0;
        end else if (!auto_active || auto_en) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + PW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_meta <= 1'b0;
            sync_btn  <= 1'b0;
        end else begin
            sync_meta <= step_btn;
            sync_btn  <= sync_meta;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            deb_state <= IDLE_LOW;
            deb_cnt   <= '0;
        end else begin
            deb_state <= deb_state_next;
            deb_cnt   <= deb_cnt_next;
        end
    end

    // Only the rising-level acceptance emits a step; the release path just re-arms.
    always_comb begin
        deb_state_next = deb_state;
        deb_cnt_next   = deb_cnt;
        step_en        = 1'b0;
        case (deb_state)
            IDLE_LOW: begin
                if (sync_btn) begin
                    deb_state_next = WAIT_HIGH;
                    deb_cnt_next   = '0;
                end
            end
            WAIT_HIGH: begin
                if (!sync_btn) begin
                    deb_state_next = IDLE_LOW;
                end else if (deb_cnt == DEB_MAX) begin
                    deb_state_next = HIGH;
                    step_en        = 1'b1;
                end else begin
                    deb_cnt_next = deb_cnt + DW'(1);
                end
            end
            HIGH: begin
                if (!sync_btn) begin
                    deb_state_next = WAIT_LOW;
                    deb_cnt_next   = '0;
                end
            end
            WAIT_LOW: begin
                if (sync_btn) begin
                    deb_state_next = HIGH;
                end else if (deb_cnt == DEB_MAX) begin
                    deb_state_next = IDLE_LOW;
                end else begin
                    deb_cnt_next = deb_cnt + DW'(1);
                end
            end
            default: deb_state_next = IDLE_LOW;
        endcase
    end

    assign count_en = manual_mode ? step_en : auto_en;

    // Load wins; a count request in the same cycle is lost rather than queued.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q    <= '0;
            tick <= 1'b0;
            wrap <= 1'b0;
        end else if (load) begin
            q    <= load_val;
            tick <= 1'b0;
            wrap <= 1'b0;
        end else if (count_en) begin
            tick <= 1'b1;
            if (up_dn) begin
                q    <= q + WIDTH'(1);
                wrap <= &q;
            end else begin
                q    <= q - WIDTH'(1);
                wrap <= ~|q;
            end
        end else begin
            tick <= 1'b0;
            wrap <= 1'b0;
        end
    end

endmodule

// File: tb/tb_binary_counter_core.sv
// tb/tb_binary_counter_core.sv - directed vector bench for binary_counter_core
module tb_binary_counter_core;

    logic       clk = 1'b0;
    logic       reset;
    logic       run;
    logic       manual_mode;
    logic       step_btn;
    logic       up_dn;
    logic       load;
    logic [5:0] load_val;
    logic [5:0] q;
    logic       tick;
    logic       wrap;

    int total = 0;
    int bad   = 0;

    binary_counter_core #(
        .WIDTH(6),
        .CLK_HZ(10),
        .TICK_HZ(1),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .run(run),
        .manual_mode(manual_mode),
        .step_btn(step_btn),
        .up_dn(up_dn),
        .load(load),
        .load_val(load_val),
        .q(q),
        .tick(tick),
        .wrap(wrap)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v_run;
        logic       v_manual;
        logic       v_up;
        logic       v_load;
        logic [5:0] v_val;
        int         cycles;
        logic [5:0] exp_q;
        logic       exp_tick;
        logic       exp_wrap;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int ticks;

        vecs[0]  = '{1'b1, 1'b0, 1'b1, 1'b1, 6'h3E, 1, 6'h3E, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 6'h00, 8, 6'h3E, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 6'h00, 1, 6'h3F, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 6'h00, 9, 6'h3F, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 6'h00, 1, 6'h00, 1'b1, 1'b1};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 6'h00, 1, 6'h00, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 6'h00, 8, 6'h00, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 6'h00, 1, 6'h3F, 1'b1, 1'b1};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 6'h00, 9, 6'h3F, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 6'h05, 1, 6'h05, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 6'h00, 9, 6'h05, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 6'h00, 1, 6'h04, 1'b1, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 6'h00, 5, 6'h04, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 2, 6'h04, 1'b0, 1'b0};
        vecs[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 6'h00, 9, 6'h04, 1'b0, 1'b0};
        vecs[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 6'h00, 1, 6'h03, 1'b1, 1'b0};

        reset = 1'b1; run = 1'b0; manual_mode = 1'b0; step_btn = 1'b0;
        up_dn = 1'b1; load = 1'b0; load_val = 6'h00;
        repeat (2) step();
        check("reset q", 32'(q), 32'h0);
        check("reset tick", 32'(tick), 32'h0);
        check("reset wrap", 32'(wrap), 32'h0);

        reset = 1'b0;
        run = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            step();
            check($sformatf("auto%0d q", i), 32'(q), 32'(i / 10));
            check($sformatf("auto%0d tick", i), 32'(tick), 32'((i % 10) == 0));
            check($sformatf("auto%0d wrap", i), 32'(wrap), 32'h0);
        end

        for (int i = 0; i < 16; i++) begin
            run = vecs[i].v_run;
            manual_mode = vecs[i].v_manual;
            up_dn = vecs[i].v_up;
            load = vecs[i].v_load;
            load_val = vecs[i].v_val;
            repeat (vecs[i].cycles) step();
            load = 1'b0;
            check($sformatf("vec%0d q", i), 32'(q), 32'(vecs[i].exp_q));
            check($sformatf("vec%0d tick", i), 32'(tick), 32'(vecs[i].exp_tick));
            check($sformatf("vec%0d wrap", i), 32'(wrap), 32'(vecs[i].exp_wrap));
        end

        // Button presses must be ignored while in auto mode.
        run = 1'b0; manual_mode = 1'b0; up_dn = 1'b1;
        ticks = 0;
        step_btn = 1'b1;
        repeat (20) begin step(); ticks += int'(tick); end
        step_btn = 1'b0;
        repeat (10) begin step(); ticks += int'(tick); end
        check("auto btn q", 32'(q), 32'h03);
        check("auto btn ticks", 32'(ticks), 32'h0);

        manual_mode = 1'b1;
        ticks = 0;
        step_btn = 1'b1;
        repeat (3) begin step(); ticks += int'(tick); end
        step_btn = 1'b0;
        repeat (10) begin step(); ticks += int'(tick); end
        check("glitch q", 32'(q), 32'h03);
        check("glitch ticks", 32'(ticks), 32'h0);

        ticks = 0;
        step_btn = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            step();
            ticks += int'(tick);
            if (i == 6) check("press e6 q", 32'(q), 32'h03);
            if (i == 7) begin
                check("press e7 q", 32'(q), 32'h04);
                check("press e7 tick", 32'(tick), 32'h1);
            end
        end
        check("press q", 32'(q), 32'h04);
        check("press ticks", 32'(ticks), 32'h1);

        ticks = 0;
        for (int i = 0; i < 4; i++) begin
            step_btn = i[0] ? 1'b1 : 1'b0;
            repeat (2) begin step(); ticks += int'(tick); end
        end
        step_btn = 1'b0;
        repeat (20) begin step(); ticks += int'(tick); end
        check("bounce q", 32'(q), 32'h04);
        check("bounce ticks", 32'(ticks), 32'h0);

        load = 1'b1; load_val = 6'h15;
        step();
        load = 1'b0;
        check("load15 q", 32'(q), 32'h15);
        step_btn = 1'b1;
        repeat (4) step();
        check("preres q", 32'(q), 32'h15);
        #2 reset = 1'b1;
        #1;
        check("async q", 32'(q), 32'h0);
        check("async tick", 32'(tick), 32'h0);
        check("async wrap", 32'(wrap), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        ticks = 0;
        for (int i = 1; i <= 12; i++) begin
            step();
            ticks += int'(tick);
            if (i == 6) check("post e6 q", 32'(q), 32'h0);
            if (i == 7) begin
                check("post e7 q", 32'(q), 32'h1);
                check("post e7 tick", 32'(tick), 32'h1);
            end
        end
        check("post q", 32'(q), 32'h1);
        check("post ticks", 32'(ticks), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
